// File: rtl/register_bank_pkg.sv
// Shared definitions for the MIPS register file: sizes, the zero-register
// address and the states of the register-dump sequencer.
package register_bank_pkg;

    localparam int DATA_SIZE = 32;
    localparam int REG_SIZE  = 5;
    localparam int REG_COUNT = 2 ** REG_SIZE;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    // True when an address refers to the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [REG_SIZE-1:0] addr);
        return (addr == REG_SIZE'(REG_ZERO));
    endfunction

endpackage

// File: rtl/register_bank_dump_ctrl.sv
// Register-dump sequencer: walks the index 0..REG_COUNT-1 under a
// valid/ready handshake and pulses done once after the last word is taken.
module reg_dump_ctrl
    import register_bank_pkg::*;
#(
    parameter int REG_SIZE = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_dump_start,
    input  logic                i_dump_ready,
    output logic                o_dump_valid,
    output logic                o_dump_done,
    output logic [REG_SIZE-1:0] o_dump_index
);

    localparam logic [REG_SIZE-1:0] LAST_INDEX = {REG_SIZE{1'b1}};

    dump_state_t         state_r;
    logic [REG_SIZE-1:0] index_r;
    logic                valid_r;
    logic                done_r;

    // Dump FSM with registered valid/done flags and index counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            index_r <= {REG_SIZE{1'b0}};
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_dump_start) begin
                        state_r <= ST_DUMP;
                        index_r <= {REG_SIZE{1'b0}};
                        valid_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (i_dump_ready) begin
                        if (index_r == LAST_INDEX) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            index_r <= index_r + {{(REG_SIZE-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        index_r <= index_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    index_r <= {REG_SIZE{1'b0}};
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dump_valid = valid_r;
    assign o_dump_done  = done_r;
    assign o_dump_index = index_r;

endmodule

// File: rtl/register_bank.sv
// MIPS register file: 32 GPRs with zero register, two bypassed read ports,
// sticky halt flag and a handshaked register-dump stream for the debug UART.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int REG_COUNT = 2 ** REG_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_reg_write,
    input  logic [REG_SIZE-1:0]  i_write_reg,
    input  logic [DATA_SIZE-1:0] i_write_data,
    input  logic                 i_halt,
    input  logic [REG_SIZE-1:0]  i_rs_addr,
    input  logic [REG_SIZE-1:0]  i_rt_addr,
    output logic [DATA_SIZE-1:0] o_rs_data,
    output logic [DATA_SIZE-1:0] o_rt_data,
    output logic                 o_halted,
    input  logic                 i_dump_start,
    input  logic                 i_dump_ready,
    output logic                 o_dump_valid,
    output logic [DATA_SIZE-1:0] o_dump_data,
    output logic                 o_dump_done
);

    logic [DATA_SIZE-1:0] regs_r [REG_COUNT];
    logic                 halted_r;
    logic                 write_s;
    logic [REG_SIZE-1:0]  dump_index_s;
    logic [DATA_SIZE-1:0] rs_data_s;
    logic [DATA_SIZE-1:0] rt_data_s;
    logic [DATA_SIZE-1:0] dump_data_s;

    assign write_s = i_enable && i_reg_write && !is_zero_reg(i_write_reg);

    // Register storage; reset clears every entry and beats a concurrent write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_SIZE{1'b0}};
            end
        end else if (write_s) begin
            regs_r[i_write_reg] <= i_write_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Sticky halt, only captured while the pipeline advances.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            halted_r <= 1'b0;
        end else if (i_enable && i_halt) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Read ports: zero register first, then same-cycle write bypass.
    always_comb begin
        rs_data_s = {DATA_SIZE{1'b0}};
        rt_data_s = {DATA_SIZE{1'b0}};
        if (is_zero_reg(i_rs_addr)) begin
            rs_data_s = {DATA_SIZE{1'b0}};
        end else if (write_s && (i_rs_addr == i_write_reg)) begin
            rs_data_s = i_write_data;
        end else begin
            rs_data_s = regs_r[i_rs_addr];
        end
        if (is_zero_reg(i_rt_addr)) begin
            rt_data_s = {DATA_SIZE{1'b0}};
        end else if (write_s && (i_rt_addr == i_write_reg)) begin
            rt_data_s = i_write_data;
        end else begin
            rt_data_s = regs_r[i_rt_addr];
        end
    end

    // Dump word shows stored contents only (no bypass), zero when idle.
    always_comb begin
        dump_data_s = {DATA_SIZE{1'b0}};
        if (o_dump_valid) begin
            dump_data_s = regs_r[dump_index_s];
        end else begin
            dump_data_s = {DATA_SIZE{1'b0}};
        end
    end

    reg_dump_ctrl #(
        .REG_SIZE (REG_SIZE)
    ) u_dump_ctrl (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_done  (o_dump_done),
        .o_dump_index (dump_index_s)
    );

    assign o_rs_data   = rs_data_s;
    assign o_rt_data   = rt_data_s;
    assign o_halted    = halted_r;
    assign o_dump_data = dump_data_s;

endmodule

// File: tb/tb_register_bank.sv
// Directed, table-driven bench for register_bank plus dump handshake sequences.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset, enable, reg_write, halt;
    logic [4:0]  write_reg, rs_addr, rt_addr;
    logic [31:0] write_data;
    logic [31:0] rs_data, rt_data, dump_data;
    logic        halted, dump_start, dump_ready, dump_valid, dump_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_bank dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_reg_write  (reg_write),
        .i_write_reg  (write_reg),
        .i_write_data (write_data),
        .i_halt       (halt),
        .i_rs_addr    (rs_addr),
        .i_rt_addr    (rt_addr),
        .o_rs_data    (rs_data),
        .o_rt_data    (rt_data),
        .o_halted     (halted),
        .i_dump_start (dump_start),
        .i_dump_ready (dump_ready),
        .o_dump_valid (dump_valid),
        .o_dump_data  (dump_data),
        .o_dump_done  (dump_done)
    );

    typedef struct {
        logic        rst, en, we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        hlt;
        logic [4:0]  rs, rt;
        logic [31:0] ers, ert;
        logic        eh;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mkv(logic rst, logic en, logic we, logic [4:0] wreg,
                                 logic [31:0] wdata, logic hlt, logic [4:0] rs,
                                 logic [4:0] rt, logic [31:0] ers, logic [31:0] ert,
                                 logic eh);
        vec_t v;
        v.rst = rst; v.en = en; v.we = we; v.wreg = wreg; v.wdata = wdata;
        v.hlt = hlt; v.rs = rs; v.rt = rt; v.ers = ers; v.ert = ert; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one dump (start already idle), checking every word and the done pulse.
    task automatic run_dump(input bit toggle_ready, input bit expect_zero);
        int  idx;
        int  done_cnt;
        bit  finished;
        logic [31:0] exp;
        dump_start = 1'b1;
        dump_ready = 1'b0;
        tick();
        idx = 0;
        done_cnt = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            dump_ready = toggle_ready ? cyc[0] : 1'b1;
            dump_start = (cyc < 3) ? 1'b1 : 1'b0;
            #4;
            if (dump_done) begin
                chk("done_after_last", idx, 32);
                chk("valid_low_in_done", {31'd0, dump_valid}, 32'd0);
                done_cnt++;
                finished = 1'b1;
            end else begin
                exp = expect_zero ? 32'd0 : 32'(idx * 4);
                chk("dump_valid", {31'd0, dump_valid}, 32'd1);
                chk($sformatf("dump_word_%0d", idx), dump_data, exp);
                if (dump_ready) idx++;
            end
            tick();
        end
        chk("done_pulse_count", done_cnt, 1);
        dump_start = 1'b0;
        dump_ready = 1'b0;
        #4;
        chk("done_single_pulse", {31'd0, dump_done}, 32'd0);
        chk("valid_idle_after", {31'd0, dump_valid}, 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; reg_write = 1'b0; halt = 1'b0;
        write_reg = 5'd0; write_data = 32'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        dump_start = 1'b0; dump_ready = 1'b0;

        vecs[0]  = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  5'd31, 32'h0,        32'h0,        1'b0);
        vecs[1]  = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd17, 32'h0,        32'h0,        1'b0);
        vecs[2]  = mkv(1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        vecs[3]  = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0);
        vecs[4]  = mkv(1'b0, 1'b1, 1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0);
        vecs[5]  = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0);
        vecs[6]  = mkv(1'b0, 1'b0, 1'b1, 5'd7,  32'hAAAA5555, 1'b0, 5'd7,  5'd7,  32'h0,        32'h0,        1'b0);
        vecs[7]  = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd7,  32'h0,        32'h0,        1'b0);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b1, 5'd31, 32'h40,       1'b1, 5'd31, 5'd3,  32'h40,       32'h0,        1'b0);
        vecs[9]  = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd31, 32'h40,       32'h40,       1'b1);
        vecs[10] = mkv(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd5,  32'h40,       32'hDEADBEEF, 1'b1);
        vecs[11] = mkv(1'b0, 1'b1, 1'b1, 5'd3,  32'h11,       1'b0, 5'd3,  5'd5,  32'h11,       32'hDEADBEEF, 1'b1);
        vecs[12] = mkv(1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd31, 32'hDEADBEEF, 32'h40,       1'b1);
        vecs[13] = mkv(1'b1, 1'b1, 1'b1, 5'd5,  32'h99,       1'b0, 5'd31, 5'd3,  32'h0,        32'h0,        1'b0);
        vecs[14] = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd5,  32'h0,        32'h0,        1'b0);
        vecs[15] = mkv(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  32'h0,        32'h0,        1'b0);
        vecs[16] = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd3,  32'h0,        32'h0,        1'b0);
        vecs[17] = mkv(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd1,  32'h0,        32'h0,        1'b0);

        tick();
        tick();
        reset = 1'b0;
        enable = 1'b1;

        // Every address reads zero after reset.
        for (int k = 0; k < 32; k++) begin
            rs_addr = 5'(k);
            rt_addr = 5'(31 - k);
            #4;
            chk($sformatf("reset_rs_%0d", k), rs_data, 32'd0);
            chk($sformatf("reset_rt_%0d", k), rt_data, 32'd0);
            tick();
        end
        #4;
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_dump_valid", {31'd0, dump_valid}, 32'd0);
        chk("reset_dump_done", {31'd0, dump_done}, 32'd0);
        chk("reset_dump_data", dump_data, 32'd0);
        tick();

        for (int i = 0; i < 18; i++) begin
            reset = vecs[i].rst; enable = vecs[i].en; reg_write = vecs[i].we;
            write_reg = vecs[i].wreg; write_data = vecs[i].wdata; halt = vecs[i].hlt;
            rs_addr = vecs[i].rs; rt_addr = vecs[i].rt;
            #4;
            chk($sformatf("vec%0d_rs", i), rs_data, vecs[i].ers);
            chk($sformatf("vec%0d_rt", i), rt_data, vecs[i].ert);
            chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].eh});
            tick();
        end
        reset = 1'b0; enable = 1'b1; reg_write = 1'b0; halt = 1'b0;

        // Preload reg k = k*4, then dump with ready toggling.
        for (int k = 1; k < 32; k++) begin
            reg_write = 1'b1;
            write_reg = 5'(k);
            write_data = 32'(k * 4);
            tick();
        end
        reg_write = 1'b0;
        run_dump(1'b1, 1'b0);

        // Reset in the middle of a dump at index 10.
        dump_start = 1'b1;
        dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        dump_ready = 1'b0;
        #4;
        chk("mid_dump_valid", {31'd0, dump_valid}, 32'd1);
        chk("mid_dump_word10", dump_data, 32'd40);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("post_reset_valid", {31'd0, dump_valid}, 32'd0);
            chk("post_reset_done", {31'd0, dump_done}, 32'd0);
            tick();
        end
        run_dump(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
